lfsr16_prbs_checker: RTL and testbench
======================================

Name: lfsr16_prbs_checker

Overview:
Receive-side companion to the 16-bit Fibonacci LFSR generator (x^16+x^14+x^13+x^11+1), which emits its serial bit on out[16].
- Self-synchronises to the incoming serial PRBS stream and then free-runs a local predictor.
- Compares every received bit with the prediction, flags and counts errors, and declares or drops lock.
- Sits at the far end of the serial link and replaces file dumping of out[16] for checking.

Parameters:
LFSR_W, 16, predictor history length in bits.
TAP_MASK, 16'hB400, bit k set means the bit received k+1 valid samples earlier feeds the XOR (delays 16, 14, 13, 11).
VERIFY_LEN, 32, consecutive correct predictions required before lock.
WIN_LEN, 64, size of the lock-loss window in valid samples.
ERR_LIMIT, 8, errors within one window that force loss of lock.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
bit_valid  in  1  qualifies bit_in for this cycle.
bit_in  in  1  received serial PRBS bit.
clr_cnt  in  1  synchronous clear of err_count and bits_checked.
locked  out  1  registered; high while in LOCKED.
err_pulse  out  1  registered one-cycle pulse per mismatched sample while LOCKED.
err_count  out  CNT_W  saturating count of errors seen while LOCKED.
bits_checked  out  CNT_W  saturating count of valid samples compared while LOCKED.

Behaviour:
- Reset: state=FILL; history, fill_cnt, match_cnt, win_cnt and win_err all 0; all outputs 0. Reset mid-operation gives the same values the next cycle, and overrides every other input.
- Cycles with bit_valid=0: nothing changes except clr_cnt; err_pulse is 0.
- Prediction: pred = XOR of history[k] over every k with TAP_MASK[k]=1. history[0] is the newest sample.
- FILL: each valid bit shifts bit_in into history and increments fill_cnt. When fill_cnt reaches LFSR_W, go to VERIFY with match_cnt=0.
- VERIFY: each valid bit is compared with pred and shifts bit_in into history (self-synchronising).
  - Match: match_cnt increments. On the VERIFY_LEN-th match, go to LOCKED.
  - Mismatch: go to FILL with fill_cnt=0; history is kept.
  - All-zero guard: if history is all zeros at compare time, treat it as a mismatch. The checker never locks on a dead line.
- LOCKED: each valid bit increments bits_checked, then shifts pred (not bit_in) into history, so the predictor flywheels. One channel bit error therefore gives exactly one error.
  - Mismatch: err_pulse=1 on the next cycle; err_count and win_err increment.
  - win_cnt increments per valid bit. At WIN_LEN, win_cnt and win_err clear; an error on the window's last sample counts before the clear.
  - When win_err reaches ERR_LIMIT, go to FILL with fill_cnt=0, and clear win_cnt and win_err. err_pulse and the count for that sample still occur.
- Latency: locked is 1 in the cycle after the clock edge that samples the VERIFY_LEN-th match, and 0 in the cycle after the edge that samples the lock-losing error. A clean start locks after LFSR_W+VERIFY_LEN = 48 valid bits.
- Counters saturate at all-ones and never wrap. clr_cnt has priority over an increment in the same cycle, so the result is 0.
- bits_checked and err_count are cumulative across lock losses until rst or clr_cnt.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W and the default TAP_MASK constant, shared with the generator;
  - the state enum typedef {FILL, VERIFY, LOCKED};
  - a CNT_W-agnostic saturating-increment function.
- One natural sub-module, lfsr_predictor: the history shift register with a select between bit_in and pred, plus the tap XOR. The top holds the FSM, window logic and counters.

Test Plan:
- Generator seeded 16'hACE1 drives bit_in with bit_valid=1 → locked rises in the cycle after the 48th bit; after 1000 further bits err_count=0 and bits_checked=1000.
- Invert the 200th bit after lock → exactly one err_pulse, err_count=1, locked stays 1, no further errors.
- After lock, invert 8 bits inside one 64-sample window → locked=0 in the cycle after the 8th error, err_count=8; relock 48 valid bits later.
- bit_in=0 for 500 valid cycles, then bit_in=1 for 500 valid cycles → locked never rises; both counters stay 0.
- Same stream as test 1 with bit_valid high only every 3rd cycle → lock after 48 valid samples, results identical to test 1.
- rst pulsed while locked, with clr_cnt and an error on the same cycle → all outputs 0 the next cycle; then clr_cnt alone, coinciding with an error, gives err_count=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit PRBS generator/checker pair.
// Holds the LFSR width, default tap mask, checker FSM states and a width-agnostic saturating increment.
package lfsr_pkg;

    localparam int              LFSR_W       = 16;
    // x^16+x^14+x^13+x^11+1: taps at delays 16, 14, 13, 11
    localparam logic [15:0]     TAP_MASK_DEF = 16'hB400;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Callers zero-extend their counter into 64 bits and take back the low w bits.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/lfsr_predictor.sv
// History shift register plus tap XOR; history[0] is the newest sample.
// The shifted-in bit is either the received bit (acquisition) or the prediction (flywheel).
module lfsr_predictor
    import lfsr_pkg::*;
#(
    parameter int               W    = lfsr_pkg::LFSR_W,
    parameter logic [W-1:0]     TAPS = lfsr_pkg::TAP_MASK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic use_pred,
    input  logic bit_in,
    output logic pred,
    output logic all_zero
);

    logic [W-1:0] history;

    always_ff @(posedge clk) begin
        if (rst)
            history <= '0;
        else if (shift_en)
            history <= {history[W-2:0], (use_pred ? pred : bit_in)};
    end

    assign pred     = ^(history & TAPS);
    assign all_zero = (history == '0);

endmodule

// File: rtl/lfsr16_prbs_checker.sv
// Serial PRBS checker: self-synchronises on the incoming stream, then flywheels a local
// predictor, reporting per-bit errors, saturating statistics and lock state.
module lfsr16_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int                LFSR_W     = lfsr_pkg::LFSR_W,
    parameter logic [LFSR_W-1:0] TAP_MASK   = lfsr_pkg::TAP_MASK_DEF,
    parameter int                VERIFY_LEN = 32,
    parameter int                WIN_LEN    = 64,
    parameter int                ERR_LIMIT  = 8,
    parameter int                CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bits_checked
);

    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(VERIFY_LEN + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

    state_t             state;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WERR_W-1:0]  win_err;

    logic               pred;
    logic               all_zero;
    logic               mismatch;
    logic [WERR_W-1:0]  win_err_n;
    logic [63:0]        err_inc;
    logic [63:0]        bits_inc;

    lfsr_predictor #(
        .W    (LFSR_W),
        .TAPS (TAP_MASK)
    ) u_pred (
        .clk      (clk),
        .rst      (rst),
        .shift_en (bit_valid),
        .use_pred (state == LOCKED),
        .bit_in   (bit_in),
        .pred     (pred),
        .all_zero (all_zero)
    );

    assign mismatch  = (bit_in != pred);
    assign win_err_n = win_err + WERR_W'(mismatch);
    assign err_inc   = sat_inc(64'(err_count), CNT_W);
    assign bits_inc  = sat_inc(64'(bits_checked), CNT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            fill_cnt     <= '0;
            match_cnt    <= '0;
            win_cnt      <= '0;
            win_err      <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            bits_checked <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == FILL_W'(LFSR_W - 1)) begin
                            state     <= VERIFY;
                            match_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        // An all-zero history predicts zeros forever; never accept it as sync.
                        if (mismatch || all_zero) begin
                            state    <= FILL;
                            fill_cnt <= '0;
                        end else if (match_cnt == MATCH_W'(VERIFY_LEN - 1)) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        bits_checked <= bits_inc[CNT_W-1:0];
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            err_count <= err_inc[CNT_W-1:0];
                        end
                        if (mismatch && (win_err_n == WERR_W'(ERR_LIMIT))) begin
                            state    <= FILL;
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err_n;
                        end
                    end
                    default: begin
                        state  <= FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Last assignment wins, so a clear beats a same-cycle increment.
            if (clr_cnt) begin
                err_count    <= '0;
                bits_checked <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr16_prbs_checker.sv
// Directed bench for lfsr16_prbs_checker: clean lock, single error, lock loss/relock,
// dead line, sparse valid, and reset/clear priority.
module tb_lfsr16_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] bits_checked;

    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    logic [15:0] g;

    lfsr16_prbs_checker dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .clr_cnt      (clr_cnt),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .bits_checked (bits_checked)
    );

    always #5 clk = ~clk;

    // One clock: drive on negedge, sample 1ns after the posedge.
    task automatic step(input logic r, input logic v, input logic b, input logic c);
        @(negedge clk);
        rst = r; bit_valid = v; bit_in = b; clr_cnt = c;
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
    endtask

    // Generator model: g[0] newest, new bit = XOR of delays 16,14,13,11.
    task automatic gen(output logic b);
        b = g[15] ^ g[13] ^ g[12] ^ g[10];
        g = {g[14:0], b};
    endtask

    task automatic send(input logic inv);
        logic b;
        gen(b);
        step(1'b0, 1'b1, b ^ inv, 1'b0);
    endtask

    task automatic send_sparse();
        logic b;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        gen(b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        g = 16'hACE1;
        pulses = 0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", err_pulse); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
        total++; if (bits_checked !== 32'd0) begin bad++; $display("FAIL reset_bits got=%0d want=0", bits_checked); end
    endtask

    task automatic test_lock_clean();
        restart();
        repeat (47) send(1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL clean_early got=%b want=0", locked); end
        send(1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_lock48 got=%b want=1", locked); end
        repeat (1000) send(1'b0);
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL clean_errcnt got=%0d want=0", err_count); end
        total++; if (bits_checked !== 32'd1000) begin bad++; $display("FAIL clean_bits got=%0d want=1000", bits_checked); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL clean_pulses got=%0d want=0", pulses); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_hold got=%b want=1", locked); end
    endtask

    task automatic test_single_error();
        int dropped = 0;
        restart();
        repeat (48) send(1'b0);
        for (int i = 1; i <= 300; i++) begin
            send(i == 200);
            if (i == 200) begin
                total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL single_pulse got=%b want=1", err_pulse); end
            end
            if (!locked) dropped++;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", pulses); end
        total++; if (err_count !== 32'd1) begin bad++; $display("FAIL single_errcnt got=%0d want=1", err_count); end
        total++; if (dropped !== 0) begin bad++; $display("FAIL single_lockdrop got=%0d want=0", dropped); end
        total++; if (bits_checked !== 32'd300) begin bad++; $display("FAIL single_bits got=%0d want=300", bits_checked); end
    endtask

    task automatic test_lose_lock();
        restart();
        repeat (48) send(1'b0);
        // errors on post-lock samples 3,5,...,17: eight within the first window
        for (int i = 1; i <= 17; i++) begin
            send((i >= 3) && (i % 2 == 1));
            if (i == 15) begin
                total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_after7 got=%b want=1", locked); end
            end
        end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_after8 got=%b want=0", locked); end
        total++; if (err_count !== 32'd8) begin bad++; $display("FAIL loss_errcnt got=%0d want=8", err_count); end
        total++; if (bits_checked !== 32'd17) begin bad++; $display("FAIL loss_bits got=%0d want=17", bits_checked); end
        repeat (47) send(1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got=%b want=0", locked); end
        send(1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock48 got=%b want=1", locked); end
        total++; if (err_count !== 32'd8) begin bad++; $display("FAIL relock_errcnt got=%0d want=8", err_count); end
    endtask

    task automatic test_dead_line();
        int seen = 0;
        restart();
        repeat (500) begin step(1'b0, 1'b1, 1'b0, 1'b0); if (locked) seen++; end
        repeat (500) begin step(1'b0, 1'b1, 1'b1, 1'b0); if (locked) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL dead_locked got=%0d want=0", seen); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL dead_errcnt got=%0d want=0", err_count); end
        total++; if (bits_checked !== 32'd0) begin bad++; $display("FAIL dead_bits got=%0d want=0", bits_checked); end
    endtask

    task automatic test_sparse_valid();
        restart();
        repeat (47) send_sparse();
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL sparse_early got=%b want=0", locked); end
        send_sparse();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL sparse_lock48 got=%b want=1", locked); end
        repeat (1000) send_sparse();
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL sparse_errcnt got=%0d want=0", err_count); end
        total++; if (bits_checked !== 32'd1000) begin bad++; $display("FAIL sparse_bits got=%0d want=1000", bits_checked); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL sparse_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_reset_clear_priority();
        logic b;
        restart();
        repeat (48) send(1'b0);
        repeat (20) send(1'b0);
        gen(b);
        step(1'b1, 1'b1, ~b, 1'b1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked got=%b want=0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL midrst_pulse got=%b want=0", err_pulse); end
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL midrst_errcnt got=%0d want=0", err_count); end
        total++; if (bits_checked !== 32'd0) begin bad++; $display("FAIL midrst_bits got=%0d want=0", bits_checked); end
        repeat (48) send(1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL midrst_relock got=%b want=1", locked); end
        repeat (5) send(1'b0);
        total++; if (bits_checked !== 32'd5) begin bad++; $display("FAIL clr_prebits got=%0d want=5", bits_checked); end
        gen(b);
        step(1'b0, 1'b1, ~b, 1'b1);
        total++; if (err_count !== 32'd0) begin bad++; $display("FAIL clr_errcnt got=%0d want=0", err_count); end
        total++; if (bits_checked !== 32'd0) begin bad++; $display("FAIL clr_bits got=%0d want=0", bits_checked); end
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b want=1", err_pulse); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_locked got=%b want=1", locked); end
        send(1'b0);
        send(1'b1);
        total++; if (err_count !== 32'd1) begin bad++; $display("FAIL clr_after got=%0d want=1", err_count); end
    endtask

    initial begin
        test_reset();
        test_lock_clean();
        test_single_error();
        test_lose_lock();
        test_dead_line();
        test_sparse_valid();
        test_reset_clear_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
